// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: constants and types shared by the RGB PWM output stage,
// the fade generators and the bench.
//   PWM_INTERVAL_DEF : default PWM period in clk cycles (100 us at 12 MHz)
//   CLK_HZ           : system clock frequency
//   channel_t        : channel index (red, green, blue)
package rgb_pwm_pkg;

    localparam int unsigned PWM_INTERVAL_DEF = 1200;
    localparam int unsigned CLK_HZ           = 12_000_000;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// pwm_channel: one PWM channel of rgb_pwm.
// Holds the shadow duty register, the compare against the shared period
// counter, the pin polarity and the output register.
//   clk, rst : clock, asynchronous active-high reset
//   enable   : 0 forces the pin to its off level
//   load     : high in the last cycle of a period; captures duty
//   cnt      : shared period counter
//   duty     : requested on-time in clk cycles per period
//   led      : registered pin drive (polarity set by ACTIVE_LOW)
module pwm_channel #(
    parameter int unsigned DUTY_W     = 11,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] duty,
    output logic              led
);

    logic [DUTY_W-1:0] duty_act;
    logic              on;

    // Shadow register: duty only changes at the period boundary so a pulse
    // is never truncated or stretched mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act <= '0;
        end else if (load) begin
            duty_act <= duty;
        end
    end

    // Duty values at or above the period length never fail this compare,
    // which gives a fully-on period without any clamp.
    always_comb begin
        on = enable && (cnt < duty_act);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= ACTIVE_LOW;
        end else begin
            led <= on ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel PWM output stage between the fade generators and
// the RGB LED pins. One shared period counter; each channel has its own
// shadow duty register loaded at the period boundary.
//   clk, rst        : 12 MHz clock, asynchronous active-high reset
//   enable          : 0 forces all LEDs off; counter keeps running
//   duty_r/g/b      : on-time per period in clk cycles (unsigned, unclamped)
//   led_r/g/b       : registered pin drives, polarity per ACTIVE_LOW
//   period_start    : one-cycle pulse while cnt == 0 after a wrap
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEF,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DUTY_W       = $clog2(PWM_INTERVAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_r,
    input  logic [DUTY_W-1:0] duty_g,
    input  logic [DUTY_W-1:0] duty_b,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b,
    output logic              period_start
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_INTERVAL - 1);

    logic [DUTY_W-1:0] cnt;
    logic              load;

    always_comb begin
        load = (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DUTY_W'(1);
        end
    end

    // Registered from the last count, so it is high while cnt == 0 after a
    // wrap and never in the first period after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= load;
        end
    end

    pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .cnt(cnt), .duty(duty_r), .led(led_r)
    );

    pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .cnt(cnt), .duty(duty_g), .led(led_g)
    );

    pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .cnt(cnt), .duty(duty_b), .led(led_b)
    );

endmodule

// File: tb/tb_rgb_pwm.sv
// tb_rgb_pwm: bench for rgb_pwm. Two instances (active-low and active-high
// pins) share all inputs and are checked every cycle against a period-level
// model: each period's pulse occupies the cycles 1..duty after its start
// (the whole period when duty >= interval), using the duty seen in the last
// cycle of the previous period.
module tb_rgb_pwm;
    import rgb_pwm_pkg::*;

    localparam int unsigned N = 10;
    localparam int unsigned W = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b1;
    logic [W-1:0] duty_r = '0;
    logic [W-1:0] duty_g = '0;
    logic [W-1:0] duty_b = '0;

    logic lr_l, lg_l, lb_l, ps_l;
    logic lr_h, lg_h, lb_h, ps_h;
    logic [2:0] leds_l, leds_h;

    assign leds_l = {lb_l, lg_l, lr_l};
    assign leds_h = {lb_h, lg_h, lr_h};

    always #5 clk = ~clk;

    rgb_pwm #(.PWM_INTERVAL(N), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .enable(enable),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .led_r(lr_l), .led_g(lg_l), .led_b(lb_l), .period_start(ps_l)
    );

    rgb_pwm #(.PWM_INTERVAL(N), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .enable(enable),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .led_r(lr_h), .led_g(lg_h), .led_b(lb_h), .period_start(ps_h)
    );

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset release, duty in force this period.
    int k;
    int eff[3];
    int red_low_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Offset 0 is the cycle where a new period starts; the pulse that the
    // previous period's duty produced may still cover it only if that
    // duty filled the whole period.
    function automatic bit pulse_on(input int off, input int d);
        return (off >= 1 && off <= d) || (off == 0 && d >= int'(N));
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 3; i++) eff[i] = 0;
    endtask

    task automatic step();
        int  d[3];
        bit  en;
        int  off;
        bit  exp_on[3];
        d[0] = int'(duty_r);
        d[1] = int'(duty_g);
        d[2] = int'(duty_b);
        en   = enable;
        @(posedge clk);
        #1;
        off = (k + 1) % N;
        for (int i = 0; i < 3; i++) exp_on[i] = en && pulse_on(off, eff[i]);
        if (k % N == N - 1) begin
            for (int i = 0; i < 3; i++) eff[i] = d[i];
        end
        k++;
        for (int i = 0; i < 3; i++) begin
            channel_t ch;
            ch = channel_t'(i);
            check({"led_lo_", ch.name()}, 32'(leds_l[i]), 32'(!exp_on[i]));
            check({"led_hi_", ch.name()}, 32'(leds_h[i]), 32'(exp_on[i]));
        end
        check("ps_lo", 32'(ps_l), 32'(off == 0));
        check("ps_hi", 32'(ps_h), 32'(off == 0));
        if (lr_l == 1'b0) red_low_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Bounded advance until the DUT counter (model phase) equals target.
    task automatic run_to(input int phase);
        int guard;
        guard = 0;
        while ((k % N) != phase && guard < int'(2 * N)) begin
            step();
            guard++;
        end
        check("run_to_phase", 32'(k % N), 32'(phase));
    endtask

    task automatic check_reset_levels(input string tag);
        check({tag, "_lo"}, 32'({ps_l, leds_l}), 32'(4'b0111));
        check({tag, "_hi"}, 32'({ps_h, leds_h}), 32'(4'b0000));
    endtask

    initial begin
        model_reset();
        red_low_cnt = 0;

        // Basic and extremes, duties held from reset.
        duty_r = W'(3);
        duty_g = W'(0);
        duty_b = W'(10);
        #12;
        check_reset_levels("reset");
        @(negedge clk);
        rst = 1'b0;
        red_low_cnt = 0;
        run(N);
        check("first_period_dark_r", 32'(red_low_cnt), 32'(0));
        red_low_cnt = 0;
        run(N);
        check("second_period_on_r", 32'(red_low_cnt), 32'(3));
        duty_b = W'(15);
        duty_r = W'(9);
        run(3 * N);

        // Mid-period duty change at cnt 4, then at the last count.
        duty_r = W'(2);
        run(N);
        run_to(4);
        duty_r = W'(7);
        run(2 * N);
        duty_r = W'(2);
        run(N);
        run_to(N - 1);
        duty_r = W'(7);
        red_low_cnt = 0;
        step();
        run(N);
        check("captured_at_last_r", 32'(red_low_cnt), 32'(7));

        // Enable drop at cnt 1, restore at cnt 3.
        duty_r = W'(5);
        duty_g = W'(5);
        duty_b = W'(5);
        run(N);
        run_to(1);
        enable = 1'b0;
        run_to(3);
        enable = 1'b1;
        run(2 * N);

        // Asynchronous reset between edges at cnt 5.
        run_to(5);
        #3;
        rst = 1'b1;
        #1;
        check_reset_levels("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        red_low_cnt = 0;
        run(N);
        check("post_reset_dark_r", 32'(red_low_cnt), 32'(0));
        run(N);

        // Randomized duty and enable traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) duty_r = W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) duty_g = W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) duty_b = W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
